// File: rtl/piano_pkg.sv
// Shared piano types: note codes, recorder states and the song entry passed to the player.
// Entry duration is stored at the widest supported width; narrower builds use the low bits.
package piano_pkg;

    localparam int DUR_W_MAX = 8;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_DO   = 4'd1;
    localparam logic [3:0] NOTE_RE   = 4'd2;
    localparam logic [3:0] NOTE_MI   = 4'd3;
    localparam logic [3:0] NOTE_FA   = 4'd4;
    localparam logic [3:0] NOTE_SOL  = 4'd5;
    localparam logic [3:0] NOTE_LA   = 4'd6;
    localparam logic [3:0] NOTE_SI   = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REC,
        ST_FETCH,
        ST_PRESENT
    } rec_state_t;

    typedef struct packed {
        logic [3:0]           note;
        logic [1:0]           octave;
        logic [DUR_W_MAX-1:0] dur;
    } entry_t;

    // Lowest-index pressed key wins; no key is a rest.
    function automatic logic [3:0] encode_keys(input logic [6:0] keys);
        encode_keys = NOTE_REST;
        for (int i = 6; i >= 0; i--) begin
            if (keys[i]) encode_keys = 4'(i + 1);
        end
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running strobe, one cycle high every PERIOD cycles (first strobe PERIOD-1 cycles after reset).
// No backpressure; the strobe is combinational from the counter.
module tick_gen #(
    parameter int PERIOD = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      cnt <= '0;
        else if (cnt == CW'(PERIOD - 1)) cnt <= '0;
        else                             cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == CW'(PERIOD - 1));

endmodule

// File: rtl/note_recorder.sv
// Captures tick-sampled key presses as (note, octave, duration) entries and streams them back out.
// Entry writes land the cycle after the deciding tick; playback holds each entry until play_ready.
module note_recorder
    import piano_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_MS = 10,
    parameter int DEPTH   = 32,
    parameter int DUR_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [6:0]                 keys,
    input  logic [1:0]                 octave,
    input  logic                       write_on,
    input  logic                       clear,
    input  logic                       play_start,
    input  logic                       play_ready,
    output logic                       play_valid,
    output logic [3:0]                 play_note,
    output logic [1:0]                 play_octave,
    output logic [DUR_W-1:0]           play_dur,
    output logic                       play_done,
    output logic                       rec_active,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int TICK_CYC = CLK_HZ / 1000 * TICK_MS;
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int AW       = $clog2(DEPTH);
    localparam logic [DUR_W_MAX-1:0] DUR_MAX = DUR_W_MAX'((1 << DUR_W) - 1);
    localparam logic [DUR_W_MAX-1:0] DUR_ONE = DUR_W_MAX'(1);

    logic [6:0]       keys_s1, keys_s2;
    logic [1:0]       oct_s1, oct_s2;
    logic             write_on_q;
    logic             tick;
    rec_state_t       state, state_d;
    logic [CNT_W-1:0] count_q;
    logic [AW-1:0]    idx;
    logic             seg_open, seg_open_d;
    entry_t           seg, seg_d;
    entry_t           rd_q;
    logic             done_q;
    entry_t           mem [DEPTH];

    logic             wr_rise, count_clr, done_d, idx_clr, idx_inc, wr_req, wr_en;
    logic [3:0]       samp_note;
    logic             samp_same;
    entry_t           wr_ent;
    logic [AW-1:0]    mem_addr;

    tick_gen #(.PERIOD(TICK_CYC)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign wr_rise   = write_on && !write_on_q;
    assign samp_note = encode_keys(keys_s2);
    assign samp_same = (seg.note == samp_note) && (seg.octave == oct_s2);
    assign wr_en     = wr_req && (count_q != CNT_W'(DEPTH));
    assign mem_addr  = (state == ST_FETCH) ? idx : count_q[AW-1:0];

    always_comb begin
        state_d    = state;
        count_clr  = 1'b0;
        done_d     = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        wr_req     = 1'b0;
        wr_ent     = seg;
        seg_open_d = seg_open;
        seg_d      = seg;
        unique case (state)
            ST_IDLE: begin
                if (wr_rise) begin
                    state_d    = ST_REC;
                    count_clr  = 1'b1;
                    seg_open_d = 1'b0;
                end else if (play_start) begin
                    if (count_q != '0) begin
                        state_d = ST_FETCH;
                        idx_clr = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (clear) begin
                    count_clr = 1'b1;
                end
            end
            ST_REC: begin
                if (!write_on) begin
                    // A trailing rest carries no musical content, so it is not stored.
                    state_d    = ST_IDLE;
                    seg_open_d = 1'b0;
                    wr_req     = seg_open && (seg.note != NOTE_REST);
                end else if (tick) begin
                    if (!seg_open) begin
                        if (samp_note != NOTE_REST) begin
                            seg_open_d = 1'b1;
                            seg_d      = '{note: samp_note, octave: oct_s2, dur: DUR_ONE};
                        end
                    end else if (samp_same) begin
                        if (seg.dur == DUR_MAX - DUR_ONE) begin
                            wr_req     = 1'b1;
                            wr_ent.dur = DUR_MAX;
                            seg_open_d = 1'b0;
                        end else begin
                            seg_d.dur = seg.dur + DUR_ONE;
                        end
                    end else begin
                        wr_req = 1'b1;
                        seg_d  = '{note: samp_note, octave: oct_s2, dur: DUR_ONE};
                    end
                end
            end
            ST_FETCH: state_d = ST_PRESENT;
            ST_PRESENT: begin
                if (play_ready) begin
                    if (CNT_W'(idx) + CNT_W'(1) == count_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        idx_inc = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keys_s1    <= '0;
            keys_s2    <= '0;
            oct_s1     <= '0;
            oct_s2     <= '0;
            write_on_q <= 1'b0;
            state      <= ST_IDLE;
            count_q    <= '0;
            idx        <= '0;
            seg_open   <= 1'b0;
            seg        <= '0;
            rd_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            keys_s1    <= keys;
            keys_s2    <= keys_s1;
            oct_s1     <= octave;
            oct_s2     <= oct_s1;
            write_on_q <= write_on;
            state      <= state_d;
            seg_open   <= seg_open_d;
            seg        <= seg_d;
            done_q     <= done_d;
            if (count_clr)  count_q <= '0;
            else if (wr_en) count_q <= count_q + 1'b1;
            if (idx_clr)      idx <= '0;
            else if (idx_inc) idx <= idx + 1'b1;
            if (state == ST_FETCH) rd_q <= mem[mem_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[mem_addr] <= wr_ent;
    end

    assign play_valid  = (state == ST_PRESENT);
    assign play_note   = rd_q.note;
    assign play_octave = rd_q.octave;
    assign play_dur    = rd_q.dur[DUR_W-1:0];
    assign play_done   = done_q;
    assign rec_active  = (state == ST_REC);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign count       = count_q;

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: two instances (8-bit and 3-bit durations) driven with identical stimulus.
module tb_note_recorder;
    localparam int PER   = 100;
    localparam int DEPTH = 32;

    logic       clk = 1'b0, reset = 1'b0;
    logic [6:0] keys = '0;
    logic [1:0] octave = '0;
    logic       write_on = 1'b0, clear = 1'b0, play_start = 1'b0, play_ready = 1'b0;

    logic       a_valid, a_done, a_rec, a_full, b_valid, b_done, b_rec, b_full;
    logic [3:0] a_note, b_note;
    logic [1:0] a_oct, b_oct;
    logic [7:0] a_dur;
    logic [2:0] b_dur;
    logic [5:0] a_count, b_count;

    note_recorder #(.CLK_HZ(100_000), .TICK_MS(1), .DEPTH(DEPTH), .DUR_W(8)) dut_a (
        .clk(clk), .reset(reset), .keys(keys), .octave(octave), .write_on(write_on),
        .clear(clear), .play_start(play_start), .play_ready(play_ready),
        .play_valid(a_valid), .play_note(a_note), .play_octave(a_oct), .play_dur(a_dur),
        .play_done(a_done), .rec_active(a_rec), .full(a_full), .count(a_count));

    note_recorder #(.CLK_HZ(100_000), .TICK_MS(1), .DEPTH(DEPTH), .DUR_W(3)) dut_b (
        .clk(clk), .reset(reset), .keys(keys), .octave(octave), .write_on(write_on),
        .clear(clear), .play_start(play_start), .play_ready(play_ready),
        .play_valid(b_valid), .play_note(b_note), .play_octave(b_oct), .play_dur(b_dur),
        .play_done(b_done), .rec_active(b_rec), .full(b_full), .count(b_count));

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct { int note; int oct; int dur; } ent_t;
    typedef struct { logic [6:0] mask; int oct; int ticks; } seg_t;
    typedef struct {
        int nseg; logic [6:0] mask[4]; int ticks[4]; int oct;
        int n8; int note8[4]; int dur8[4];
        int n3; int note3[4]; int dur3[4];
    } vec_t;

    seg_t segq[$];
    ent_t exp_a[$], exp_b[$], cap_a[$], cap_b[$], mq[$];
    int   nchk = 0, nerr = 0;

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int enc(input logic [6:0] m);
        for (int k = 0; k < 7; k++) if (m[k]) return k + 1;
        return 0;
    endfunction

    // Reference: run-length encode the per-tick samples, then apply the segment rules.
    task automatic model(input int dmax);
        int sn[$], so[$];
        int i;
        bit pv;
        ent_t pend;
        foreach (segq[s]) for (int t = 0; t < segq[s].ticks; t++) begin
            sn.push_back(enc(segq[s].mask));
            so.push_back(segq[s].oct);
        end
        mq.delete();
        pv = 0;
        pend = '{0, 0, 0};
        i = 0;
        while (i < sn.size()) begin
            int j, len;
            bit opened;
            j = i;
            while (j < sn.size() && sn[j] == sn[i] && so[j] == so[i]) j++;
            len = j - i;
            if (pv) begin mq.push_back(pend); pv = 0; opened = 1; end
            else opened = (sn[i] != 0);
            if (opened) begin
                if (sn[i] == 0) begin
                    if (len >= dmax) mq.push_back('{0, so[i], dmax});
                    else begin pend = '{0, so[i], len}; pv = 1; end
                end else begin
                    repeat (len / dmax) mq.push_back('{sn[i], so[i], dmax});
                    if (len % dmax != 0) begin pend = '{sn[i], so[i], len % dmax}; pv = 1; end
                end
            end
            i = j;
        end
        if (pv && pend.note != 0) mq.push_back(pend);
        while (mq.size() > DEPTH) void'(mq.pop_back());
    endtask

    task automatic align();
        while (cyc % PER != 50) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a_valid"}, a_valid, 0);  check({tag, "_a_note"}, a_note, 0);
        check({tag, "_a_oct"}, a_oct, 0);      check({tag, "_a_dur"}, a_dur, 0);
        check({tag, "_a_done"}, a_done, 0);    check({tag, "_a_rec"}, a_rec, 0);
        check({tag, "_a_full"}, a_full, 0);    check({tag, "_a_count"}, a_count, 0);
        check({tag, "_b_valid"}, b_valid, 0);  check({tag, "_b_note"}, b_note, 0);
        check({tag, "_b_dur"}, b_dur, 0);      check({tag, "_b_count"}, b_count, 0);
    endtask

    task automatic do_record(input bit chk_full);
        align();
        write_on = 1'b1;
        foreach (segq[i]) begin
            keys = segq[i].mask;
            octave = 2'(segq[i].oct);
            repeat (segq[i].ticks * PER) @(negedge clk);
        end
        if (chk_full) begin
            check("full_a_count", a_count, DEPTH); check("full_a_flag", a_full, 1);
            check("full_a_rec", a_rec, 1);         check("full_b_count", b_count, DEPTH);
        end
        keys = '0;
        write_on = 1'b0;
        repeat (3) @(negedge clk);
        check("rec_exit_a", a_rec, 0);
    endtask

    task automatic cmp_list(input string tag, input ent_t cap[$], input ent_t exp[$]);
        check({tag, "_len"}, cap.size(), exp.size());
        for (int i = 0; i < cap.size() && i < exp.size(); i++) begin
            check($sformatf("%s_note%0d", tag, i), cap[i].note, exp[i].note);
            check($sformatf("%s_oct%0d", tag, i), cap[i].oct, exp[i].oct);
            check($sformatf("%s_dur%0d", tag, i), cap[i].dur, exp[i].dur);
        end
    endtask

    task automatic do_play(input bit rnd_ready);
        int k, fa, fb, da, db, ka, kb, hsa, hsb, last, pa, pb;
        bit ha, hb;
        cap_a.delete(); cap_b.delete();
        fa = -1; fb = -1; da = 0; db = 0; ka = -1; kb = -1; hsa = -1; hsb = -1;
        last = -1; ha = 0; hb = 0; pa = 0; pb = 0;
        @(negedge clk);
        play_start = 1'b1;
        k = 0;
        while (k < 4000) begin
            play_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (ha) check("a_stable", int'({a_valid, a_note, a_oct, a_dur}), pa);
            if (hb) check("b_stable", int'({b_valid, b_note, b_oct, b_dur}), pb);
            if (a_valid && fa < 0) fa = k;
            if (b_valid && fb < 0) fb = k;
            ha = a_valid && !play_ready; pa = int'({a_valid, a_note, a_oct, a_dur});
            hb = b_valid && !play_ready; pb = int'({b_valid, b_note, b_oct, b_dur});
            if (a_valid && play_ready) begin cap_a.push_back('{a_note, a_oct, a_dur}); hsa = k; end
            if (b_valid && play_ready) begin cap_b.push_back('{b_note, b_oct, b_dur}); hsb = k; end
            if (a_done) begin da++; ka = k; end
            if (b_done) begin db++; kb = k; end
            if (da > 0 && db > 0 && last < 0) last = k;
            if (last >= 0 && k >= last + 3) break;
            @(negedge clk);
            play_start = 1'b0;
            k++;
        end
        play_ready = 1'b0;
        if (last < 0) check("play_timeout", 0, 1);
        check("a_first_valid", fa, exp_a.size() == 0 ? -1 : 2);
        check("b_first_valid", fb, exp_b.size() == 0 ? -1 : 2);
        check("a_done_cnt", da, 1);
        check("b_done_cnt", db, 1);
        check("a_done_time", ka, exp_a.size() == 0 ? 1 : hsa + 1);
        check("b_done_time", kb, exp_b.size() == 0 ? 1 : hsb + 1);
        cmp_list("a", cap_a, exp_a);
        cmp_list("b", cap_b, exp_b);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[4];
        int bad;
        int snap;
        vt[0] = '{3, '{7'h01, 7'h04, 7'h00, 7'h00}, '{5, 3, 2, 0}, 1,
                  2, '{1, 3, 0, 0}, '{5, 3, 0, 0},
                  2, '{1, 3, 0, 0}, '{5, 3, 0, 0}};
        vt[1] = '{3, '{7'h01, 7'h00, 7'h02, 7'h00}, '{2, 2, 3, 0}, 2,
                  3, '{1, 0, 2, 0}, '{2, 2, 3, 0},
                  3, '{1, 0, 2, 0}, '{2, 2, 3, 0}};
        vt[2] = '{1, '{7'h10, 7'h00, 7'h00, 7'h00}, '{10, 0, 0, 0}, 3,
                  1, '{5, 0, 0, 0}, '{10, 0, 0, 0},
                  2, '{5, 5, 0, 0}, '{7, 3, 0, 0}};
        vt[3] = '{3, '{7'h00, 7'h60, 7'h00, 7'h00}, '{2, 1, 8, 0}, 0,
                  1, '{6, 0, 0, 0}, '{1, 0, 0, 0},
                  2, '{6, 0, 0, 0}, '{1, 7, 0, 0}};

        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            segq.delete(); exp_a.delete(); exp_b.delete();
            for (int s = 0; s < vt[v].nseg; s++)
                segq.push_back('{vt[v].mask[s], vt[v].oct, vt[v].ticks[s]});
            for (int e = 0; e < vt[v].n8; e++) exp_a.push_back('{vt[v].note8[e], vt[v].oct, vt[v].dur8[e]});
            for (int e = 0; e < vt[v].n3; e++) exp_b.push_back('{vt[v].note3[e], vt[v].oct, vt[v].dur3[e]});
            do_record(0);
            check($sformatf("vec%0d_a_count", v), a_count, vt[v].n8);
            check($sformatf("vec%0d_b_count", v), b_count, vt[v].n3);
            do_play(0);
        end

        // 33 one-tick segments: the last one is discarded once the buffer is full.
        segq.delete();
        for (int s = 0; s < 33; s++) segq.push_back('{7'(1 << (s % 7)), s % 4, 1});
        model(255); exp_a = mq;
        model(7);   exp_b = mq;
        do_record(1);
        check("full_after_a", a_count, DEPTH);
        check("full_after_flag", a_full, 1);
        do_play(0);

        for (int r = 0; r < 3; r++) begin
            segq.delete();
            for (int s = 0; s < 6; s++)
                segq.push_back('{($urandom_range(0, 1) != 0) ? 7'h00 : 7'($urandom_range(1, 127)),
                                 int'($urandom_range(0, 3)), int'($urandom_range(1, 4))});
            model(255); exp_a = mq;
            model(7);   exp_b = mq;
            do_record(0);
            check($sformatf("rnd%0d_a_count", r), a_count, exp_a.size());
            check($sformatf("rnd%0d_b_count", r), b_count, exp_b.size());
            do_play(1);
        end

        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check("clear_a_count", a_count, 0);
        check("clear_b_count", b_count, 0);

        // Stall with play_ready low, then reset while an entry is presented.
        segq.delete();
        segq.push_back('{7'h01, 2, 2}); segq.push_back('{7'h00, 2, 2}); segq.push_back('{7'h02, 2, 3});
        do_record(0);
        @(negedge clk); play_start = 1'b1; play_ready = 1'b0;
        @(negedge clk); play_start = 1'b0;
        @(negedge clk);
        check("stall_valid", a_valid, 1);
        check("stall_note", a_note, 1);
        check("stall_dur", a_dur, 2);
        snap = int'({a_valid, a_note, a_oct, a_dur});
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (int'({a_valid, a_note, a_oct, a_dur}) != snap) bad++;
        end
        check("stall_changes", bad, 0);
        reset = 1'b0;
        #1;
        check_zero("rst_present");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        exp_a.delete(); exp_b.delete();
        do_play(0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/note_recorder.md
# note_recorder

Records free-play key presses as (note, octave, duration) entries into an on-chip buffer while `write_on` is high, then streams the entries back to the auto-play path on request. It is the writer side of the song interface: the controller's auto/learn player consumes what this block captures and drives the buzzer from it. It sits between the raw `keys`/`octave` inputs and the player, in parallel with the free-play note path.

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- TICK_MS, 10, duration quantum in ms; also the key sampling period
- DEPTH, 32, buffer entries
- DUR_W, 8, duration field width in ticks, saturating at 2^DUR_W-1

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- keys  in  7  raw piano keys, bit i = note i+1
- octave  in  2  octave switch, recorded with each note
- write_on  in  1  recording enable, level; rising edge arms a new recording
- clear  in  1  empties buffer, honoured in IDLE only
- play_start  in  1  single-cycle request to stream buffer out
- play_ready  in  1  consumer accepts current entry
- play_valid  out  1  play_note/octave/dur hold a valid entry
- play_note  out  4  0 = rest, 1..7 = do..si
- play_octave  out  2  recorded octave
- play_dur  out  DUR_W  duration in ticks, 1..2^DUR_W-1
- play_done  out  1  one-cycle pulse at end of stream
- rec_active  out  1  high in REC
- full  out  1  buffer holds DEPTH entries
- count  out  $clog2(DEPTH+1)  entries stored

## Operation
- keys and octave pass a 2-FF synchronizer; sampled only on tick (free-running strobe every CLK_HZ/1000*TICK_MS cycles from reset); tick sampling is the debounce.
- Encoding: lowest-index pressed key wins, note = index+1; no key = 0 (rest).
- States IDLE, REC, FETCH, PRESENT.
- IDLE: write_on rising edge -> REC, count := 0, full := 0, segment open = none. play_start with count>0 -> FETCH, idx := 0. play_start with count==0 -> play_done next cycle, stay IDLE. Simultaneous write_on edge and play_start: REC wins, play_start dropped. clear with no transition -> count := 0, full := 0.
- REC, per tick: if no segment open and sample is rest, ignore (leading rests not recorded). Otherwise if sample equals open segment (note and octave), dur += 1; if dur reaches max, write entry, reopen same note with dur 1 on next differing-or-equal tick. If sample differs, write open entry, open new segment with dur 1.
- REC exit on write_on low: write open segment unless it is a rest (trailing rest dropped), -> IDLE.
- Writes when count==DEPTH are discarded; full = (count==DEPTH). Recording continues until write_on low.
- FETCH: registered RAM read of idx, -> PRESENT. PRESENT: play_valid high, outputs stable until play_valid&&play_ready; then idx+1 == count -> play_done pulse, IDLE; else idx += 1, FETCH.
- write_on, clear, play_start ignored in FETCH/PRESENT; write_on must show a fresh rising edge after return to IDLE.

## Timing
- Reset values: all outputs 0; state IDLE; count 0; tick counter 0.
- Entry write occurs the cycle after the deciding tick; count increments in that cycle.
- play_start sampled high -> play_valid high 2 cycles later. After handshake, play_valid low for one cycle, next entry valid 2 cycles after handshake.
- play_done: one cycle, the cycle after the final handshake (or after play_start when empty).
- Reset mid-operation: immediate return to IDLE, count 0, buffer contents don't-care.

## Structure
- Shared package piano_pkg: note codes NOTE_REST=0, NOTE_DO..NOTE_SI=1..7; state enum; entry struct {note[3:0], octave[1:0], dur[DUR_W-1:0]} shared with the player.
- Sub-module tick_gen: parameterised strobe divider, reused by the player for playback timing.
- Buffer as inferred single-port RAM with registered read.

## Test plan
- CLK_HZ=100_000, TICK_MS=1 (tick every 100 cycles) for all cases.
- Raise write_on, hold key 0 for 5 ticks, key 2 for 3 ticks, release, drop write_on -> count=2, entries (1,oct,5),(3,oct,3), trailing rest dropped.
- Record key 0, release 2 ticks, key 1 -> entries (1,.,n),(0,.,2),(2,.,m); play_start with play_ready=1 -> valid 2 cycles later, 3 entries, play_done once.
- DUR_W=3, hold key 4 for 10 ticks -> entries (5,.,7),(5,.,3).
- Record 33 distinct segments -> count=32, full=1; 33rd dropped; stays REC.
- play_ready held low 50 cycles -> outputs stable; reset asserted during PRESENT -> all outputs 0, count 0; play_start with count 0 -> play_done only.
